// File: rtl/i2c_slave_sync.sv
// I2C slave bridging a small byte memory: synchronized SCL/SDA sampling, START/STOP
// detection, address match, memory-address phase, auto-incrementing write/read pointer.
module i2c_slave_sync #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         ABYTES     = 1,
    parameter int         DEPTH      = 2**(8*ABYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  busy,
    output logic                  wr_en,
    output logic [8*ABYTES-1:0]   wr_addr,
    output logic [7:0]            wr_data
);
    localparam int AW = 8*ABYTES;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      scl_sync_q, sda_sync_q;
    logic            scl_prev_q, sda_prev_q;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      tx_q, tx_d;
    logic [AW-1:0]   addr_acc_q, addr_acc_d;
    logic [1:0]      abyte_q, abyte_d;
    logic            rw_q, rw_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [7:0]      mem_q [DEPTH];

    logic            scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]      mem_rd_s;
    logic [AW-1:0]   ptr_inc_s;

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise_s = scl_s & ~scl_prev_q;
    assign scl_fall_s = ~scl_s & scl_prev_q;
    assign start_s    = scl_s & sda_prev_q & ~sda_s;
    assign stop_s     = scl_s & ~sda_prev_q & sda_s;
    assign mem_rd_s   = mem_q[ptr_q[IW-1:0]];
    assign ptr_inc_s  = (ptr_q == AW'(DEPTH-1)) ? '0 : ptr_q + AW'(1);

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // Protocol FSM: next state and datapath; START/STOP override any SCL edge
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        addr_acc_d = addr_acc_q;
        abyte_d    = abyte_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (start_s) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_s) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = 4'd0;
                end
                DEV_ADDR, MEM_ADDR, WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == WR_DATA && bit_cnt_q == 4'd7) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = {shift_q[6:0], sda_s};
                            ptr_d     = ptr_inc_s;
                        end else begin
                            wr_en_d = 1'b0;
                        end
                    end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == DEV_ADDR) begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                state_d  = DEV_ACK;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[0];
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else if (state_q == MEM_ADDR) begin
                            state_d    = MEM_ACK;
                            sda_oe_d   = 1'b1;
                            addr_acc_d = AW'({addr_acc_q, shift_q});
                            abyte_d    = abyte_q + 2'd1;
                        end else begin
                            state_d  = WR_ACK;
                            sda_oe_d = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                DEV_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d  = RD_DATA;
                            tx_d     = mem_rd_s;
                            sda_oe_d = ~mem_rd_s[7];
                        end else begin
                            state_d  = MEM_ADDR;
                            sda_oe_d = 1'b0;
                            abyte_d  = 2'd0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                MEM_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        if (abyte_q == 2'(ABYTES)) begin
                            state_d = WR_DATA;
                            ptr_d   = AW'(32'(addr_acc_q) % DEPTH);
                        end else begin
                            state_d = MEM_ADDR;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_s) begin
                        state_d   = WR_DATA;
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                RD_DATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = RD_ACK;
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_inc_s;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                RD_ACK: begin
                    // bit_cnt marks that the master's ACK bit has been sampled
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall_s && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d  = RD_DATA;
                            tx_d     = mem_rd_s;
                            sda_oe_d = ~mem_rd_s[7];
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            tx_q       <= 8'd0;
            addr_acc_q <= '0;
            abyte_q    <= 2'd0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            addr_acc_q <= addr_acc_d;
            abyte_q    <= abyte_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Memory array, deliberately without reset
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[ptr_q[IW-1:0]] <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_i2c_slave_sync.sv
// Directed bench: bit-banged I2C master against a 1-byte-address and a 2-byte-address slave.
module tb_i2c_slave_sync;
    logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1, sel = 1'b0;
    logic scl1, sda1, scl2, sda2, sda_bus;
    logic oe1, busy1, wen1, oe2, busy2, wen2;
    logic [7:0] wa1, wd1, wd2;
    logic [15:0] wa2;
    int errors = 0, checks = 0;
    int oe_cnt = 0, busy_cnt = 0;
    logic [15:0] q1[$];
    logic [23:0] q2[$];

    always #5 clk = ~clk;

    assign scl1    = sel ? 1'b1 : scl_m;
    assign sda1    = sel ? 1'b1 : (sda_m & ~oe1);
    assign scl2    = sel ? scl_m : 1'b1;
    assign sda2    = sel ? (sda_m & ~oe2) : 1'b1;
    assign sda_bus = sel ? sda2 : sda1;

    i2c_slave_sync #(.SLAVE_ADDR(7'h55), .ABYTES(1), .DEPTH(256)) u_dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl1), .sda_i(sda1), .sda_oe(oe1),
        .busy(busy1), .wr_en(wen1), .wr_addr(wa1), .wr_data(wd1));

    i2c_slave_sync #(.SLAVE_ADDR(7'h55), .ABYTES(2), .DEPTH(512)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .scl_i(scl2), .sda_i(sda2), .sda_oe(oe2),
        .busy(busy2), .wr_en(wen2), .wr_addr(wa2), .wr_data(wd2));

    always @(negedge clk) begin
        if (wen1) q1.push_back({wa1, wd1});
        if (wen2) q2.push_back({wa2, wd2});
        if (oe1) oe_cnt++;
        if (busy1) busy_cnt++;
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        w(4); sda_m = b; w(4); scl_m = 1'b1; w(4); s = sda_bus; w(4); scl_m = 1'b0;
    endtask

    task automatic i2c_start;
        w(4); sda_m = 1'b1; w(4); scl_m = 1'b1; w(8); sda_m = 1'b0; w(8); scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        w(4); sda_m = 1'b0; w(4); scl_m = 1'b1; w(8); sda_m = 1'b1; w(8);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(mack, s);
    endtask

    function automatic logic [15:0] q1_at(input int idx);
        return (q1.size() > idx) ? q1[idx] : 16'h0000;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; w(3);
        checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", oe1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
        checks++; if (wen1 !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wen1); end
        checks++; if (wa1 !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", wa1); end
        checks++; if (wd1 !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wd1); end
        checks++; if (oe2 !== 1'b0) begin errors++; $display("FAIL reset_oe2: got %b want 0", oe2); end
        rst_n = 1'b1; w(4);
    endtask

    task automatic test_ack_latency;
        logic [7:0] b = 8'hAA;
        logic s;
        int lat = 0;
        i2c_start();
        for (int i = 7; i >= 1; i--) i2c_bit(b[i], s);
        w(4); sda_m = b[0]; w(4); scl_m = 1'b1; w(8); scl_m = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (oe1 && lat == 0) lat = k;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL ack_latency: got %0d clk want 3", lat); end
        w(2); sda_m = 1'b1; w(2); scl_m = 1'b1; w(8); scl_m = 1'b0;
        i2c_stop();
    endtask

    task automatic test_write;
        logic [7:0] seq [4] = '{8'hAA, 8'h10, 8'h5A, 8'hC3};
        logic a;
        int base = q1.size();
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(seq[i], a);
            checks++; if (a !== 1'b0) begin errors++; $display("FAIL write_ack[%0d]: got %b want 0", i, a); end
        end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy1); end
        i2c_stop();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b want 0", busy1); end
        checks++; if (q1.size() != base + 2) begin errors++; $display("FAIL write_count: got %0d want 2", q1.size() - base); end
        checks++; if (q1_at(base) !== 16'h105A) begin errors++; $display("FAIL write_0: got %h want 105a", q1_at(base)); end
        checks++; if (q1_at(base + 1) !== 16'h11C3) begin errors++; $display("FAIL write_1: got %h want 11c3", q1_at(base + 1)); end
    endtask

    task automatic test_random_read;
        logic a;
        logic [7:0] d;
        i2c_start(); write_byte(8'hAA, a); write_byte(8'h10, a);
        i2c_start(); write_byte(8'hAB, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", a); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rd_byte0: got %h want 5a", d); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd_byte1: got %h want c3", d); end
        w(8);
        checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL rd_release: got %b want 0", oe1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rd_busy_nack: got %b want 1", busy1); end
        i2c_stop();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rd_busy_stop: got %b want 0", busy1); end
    endtask

    task automatic test_current_read;
        logic a;
        logic [7:0] d;
        i2c_start(); write_byte(8'hAA, a); write_byte(8'h10, a);
        i2c_start(); write_byte(8'hAB, a); read_byte(1'b1, d); i2c_stop();
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL cur_first: got %h want 5a", d); end
        i2c_start(); write_byte(8'hAB, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL cur_ack: got %b want 0", a); end
        read_byte(1'b1, d); i2c_stop();
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL cur_read: got %h want c3", d); end
    endtask

    task automatic test_mismatch;
        logic a;
        int base = q1.size();
        int oeb = oe_cnt;
        int bb = busy_cnt;
        i2c_start(); write_byte(8'hA8, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL mis_nack: got %b want 1", a); end
        write_byte(8'h5A, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL mis_data_nack: got %b want 1", a); end
        write_byte(8'h33, a); i2c_stop();
        checks++; if (oe_cnt != oeb) begin errors++; $display("FAIL mis_oe: got %0d clk want 0", oe_cnt - oeb); end
        checks++; if (busy_cnt != bb) begin errors++; $display("FAIL mis_busy: got %0d clk want 0", busy_cnt - bb); end
        checks++; if (q1.size() != base) begin errors++; $display("FAIL mis_wr: got %0d want 0", q1.size() - base); end
    endtask

    task automatic test_wrap;
        logic [7:0] seq [4] = '{8'hAA, 8'hFF, 8'h11, 8'h22};
        logic a;
        logic [7:0] d;
        int base = q1.size();
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(seq[i], a);
            checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrap_ack[%0d]: got %b want 0", i, a); end
        end
        i2c_stop();
        checks++; if (q1_at(base) !== 16'hFF11) begin errors++; $display("FAIL wrap_0: got %h want ff11", q1_at(base)); end
        checks++; if (q1_at(base + 1) !== 16'h0022) begin errors++; $display("FAIL wrap_1: got %h want 0022", q1_at(base + 1)); end
        i2c_start(); write_byte(8'hAA, a); write_byte(8'hFF, a);
        i2c_start(); write_byte(8'hAB, a);
        read_byte(1'b0, d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL wrap_rd0: got %h want 11", d); end
        read_byte(1'b1, d); i2c_stop();
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL wrap_rd1: got %h want 22", d); end
    endtask

    task automatic test_abytes2;
        logic [7:0] seq [4] = '{8'hAA, 8'h01, 8'h23, 8'h77};
        logic a;
        int base = q2.size();
        logic [23:0] got;
        sel = 1'b1; w(4);
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(seq[i], a);
            checks++; if (a !== 1'b0) begin errors++; $display("FAIL ab2_ack[%0d]: got %b want 0", i, a); end
        end
        i2c_stop();
        got = (q2.size() > base) ? q2[base] : 24'h000000;
        checks++; if (q2.size() != base + 1) begin errors++; $display("FAIL ab2_count: got %0d want 1", q2.size() - base); end
        checks++; if (got !== 24'h012377) begin errors++; $display("FAIL ab2_write: got %h want 012377", got); end
        sel = 1'b0; w(4);
    endtask

    task automatic test_abort;
        logic [7:0] seq [4] = '{8'hAA, 8'h20, 8'h0F, 8'h00};
        logic a, s;
        logic [7:0] d;
        int base = q1.size();
        int oeb, bb;
        i2c_start();
        for (int i = 0; i < 4; i++) write_byte(seq[i], a);
        i2c_stop();
        i2c_start(); write_byte(8'hAA, a); write_byte(8'h20, a);
        i2c_bit(1'b1, s); i2c_bit(1'b0, s); i2c_bit(1'b1, s); i2c_bit(1'b0, s);
        i2c_stop();
        checks++; if (q1.size() != base + 2) begin errors++; $display("FAIL abort_partial_wr: got %0d want 2", q1.size() - base); end
        i2c_start(); write_byte(8'hAA, a);
        i2c_bit(1'b0, s); i2c_bit(1'b1, s); i2c_bit(1'b0, s); i2c_bit(1'b1, s);
        i2c_stop();
        i2c_start(); write_byte(8'hAB, a);
        read_byte(1'b0, d);
        checks++; if (d !== 8'h0F) begin errors++; $display("FAIL abort_ptr_kept: got %h want 0f", d); end
        i2c_bit(1'b1, s); i2c_bit(1'b1, s);
        w(4);
        checks++; if (oe1 !== 1'b1) begin errors++; $display("FAIL abort_driving: got %b want 1", oe1); end
        rst_n = 1'b0; #1;
        checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL abort_rst_oe: got %b want 0", oe1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_rst_busy: got %b want 0", busy1); end
        w(3); rst_n = 1'b1;
        oeb = oe_cnt; bb = busy_cnt; base = q1.size();
        for (int i = 0; i < 9; i++) i2c_bit(1'b1, s);
        i2c_stop();
        checks++; if (oe_cnt != oeb) begin errors++; $display("FAIL abort_no_start_oe: got %0d clk want 0", oe_cnt - oeb); end
        checks++; if (busy_cnt != bb) begin errors++; $display("FAIL abort_no_start_busy: got %0d clk want 0", busy_cnt - bb); end
        i2c_start(); write_byte(8'hAA, a); write_byte(8'h30, a); write_byte(8'h55, a); i2c_stop();
        checks++; if (q1_at(base) !== 16'h3055) begin errors++; $display("FAIL abort_recover: got %h want 3055", q1_at(base)); end
    endtask

    initial begin
        test_reset();
        test_ack_latency();
        test_write();
        test_random_read();
        test_current_read();
        test_mismatch();
        test_wrap();
        test_abytes2();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
